dmem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory port. It serves the datapath's dmem read and write requests against a single-port synchronous data SRAM.
- Writes are posted into a small write buffer. Reads have priority on the SRAM port, and buffered data is forwarded to reads that hit a pending write.
- It sits between the datapath and the data SRAM macro. Its stall output holds the core when it cannot accept a request.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/dmem_wbuf.sv | 79 +++++++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU data-memory path.
// Used by the dmem responder and its posted-write buffer.
package cpu_pkg;

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRAM_IDLE,
    SRAM_RD,
    SRAM_DRAIN
  } sram_op_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-write FIFO for the data memory with a parallel address
// lookup that returns the youngest pending write to an address.
module dmem_wbuf
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_WIDTH,
  parameter int DATA_W   = DMEM_DATA_WIDTH,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookupAddr,
  output logic              hit,
  output logic [DATA_W-1:0] hitData,
  output logic [ADDR_W-1:0] headAddr,
  output logic [DATA_W-1:0] headData,
  output logic [$clog2(WB_DEPTH):0] count,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addrMem [WB_DEPTH];
  logic [DATA_W-1:0] dataMem [WB_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[tail] <= pushAddr;
      dataMem[tail] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit     = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < cnt) && (addrMem[idx] == lookupAddr)) begin
        hit     = 1'b1;
        hitData = dataMem[idx];
      end
    end
  end

  assign headAddr = addrMem[head];
  assign headData = dataMem[head];
  assign count    = cnt;
  assign full     = (cnt == CW'(WB_DEPTH));
  assign empty    = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted writes, read priority on the
// single SRAM port, and forwarding from pending writes.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_WIDTH,
  parameter int DATA_W   = DMEM_DATA_WIDTH,
  parameter int WB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dmem_waddr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_raddr,
  input  logic              dmem_ren,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_rvalid,
  output logic              dmem_stall,
  output logic              wb_empty,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic              wbHit;
  logic [DATA_W-1:0] wbHitData;
  logic [ADDR_W-1:0] wbHeadAddr;
  logic [DATA_W-1:0] wbHeadData;
  logic [CW-1:0]     wbCount;
  logic              wbFull;
  logic              wbEmpty;

  logic              stall;
  logic              wrAcc;
  logic              rdAcc;
  logic              rdMiss;
  logic              drainAny;
  logic              pop;
  sram_op_t          op;

  logic              rvalidQ;
  logic              hitQ;
  logic [DATA_W-1:0] fwdQ;

  dmem_wbuf #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .WB_DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wrAcc),
    .pushAddr   (dmem_waddr),
    .pushData   (dmem_wdata),
    .pop        (pop),
    .lookupAddr (dmem_raddr),
    .hit        (wbHit),
    .hitData    (wbHitData),
    .headAddr   (wbHeadAddr),
    .headData   (wbHeadData),
    .count      (wbCount),
    .full       (wbFull),
    .empty      (wbEmpty)
  );

  assign stall = wbFull & (dmem_wen | dmem_ren);
  assign wrAcc = dmem_wen & ~stall;
  assign rdAcc = dmem_ren & ~stall;

  // Mutually exclusive terms so the decoder stays unique.
  assign rdMiss   = ~wbFull & rdAcc & ~wbHit;
  assign drainAny = ~wbFull & ~rdMiss & ~wbEmpty;

  always_comb begin
    op = SRAM_IDLE;
    unique case (1'b1)
      wbFull:   op = SRAM_DRAIN;
      rdMiss:   op = SRAM_RD;
      drainAny: op = SRAM_DRAIN;
      default:  op = SRAM_IDLE;
    endcase
  end

  assign pop = (op == SRAM_DRAIN);

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (op)
      SRAM_RD: begin
        sram_en   = 1'b1;
        sram_addr = dmem_raddr;
      end
      SRAM_DRAIN: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = wbHeadAddr;
        sram_wdata = wbHeadData;
      end
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalidQ <= 1'b0;
      hitQ    <= 1'b0;
      fwdQ    <= '0;
    end else begin
      rvalidQ <= rdAcc;
      if (rdAcc) hitQ <= wbHit;
      if (rdAcc && wbHit) fwdQ <= wbHitData;
    end
  end

  always_comb begin
    dmem_rdata = '0;
    if (rvalidQ) dmem_rdata = hitQ ? fwdQ : sram_rdata;
  end

  assign dmem_rvalid = rvalidQ;
  assign dmem_stall  = stall;
  assign wb_empty    = (wbCount == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, random traffic against
// a queue-based reference model, and reset during a drain.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic        dmem_wen;
  logic [11:0] dmem_raddr;
  logic        dmem_ren;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        dmem_stall;
  logic        wb_empty;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmem_waddr  (dmem_waddr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wen    (dmem_wen),
    .dmem_raddr  (dmem_raddr),
    .dmem_ren    (dmem_ren),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .dmem_stall  (dmem_stall),
    .wb_empty    (wb_empty),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  logic [31:0] mem [0:4095];

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        pq[$];
  logic [31:0] memModel [0:4095];
  logic        expRv;
  logic [31:0] expRd;
  logic        mStall;
  int          vectors;
  int          miscompares;

  typedef struct {
    logic        wen;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        ren;
    logic [11:0] ra;
    logic        st;
    logic        em;
    logic        en;
    logic        we;
    logic [11:0] sa;
    logic [31:0] sw;
    logic        rv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t V(
    input logic wen, input logic [11:0] wa, input logic [31:0] wd,
    input logic ren, input logic [11:0] ra,
    input logic st, input logic em, input logic en, input logic we,
    input logic [11:0] sa, input logic [31:0] sw,
    input logic rv, input logic [31:0] rd);
    vec_t v;
    v.wen = wen; v.wa = wa; v.wd = wd; v.ren = ren; v.ra = ra;
    v.st = st; v.em = em; v.en = en; v.we = we;
    v.sa = sa; v.sw = sw; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic wen, input logic [11:0] wa,
                       input logic [31:0] wd, input logic ren,
                       input logic [11:0] ra);
    dmem_wen   = wen;
    dmem_waddr = wa;
    dmem_wdata = wd;
    dmem_ren   = ren;
    dmem_raddr = ra;
  endtask

  // Called at posedge+1 with inputs driven; checks mid-cycle.
  task automatic modelCheck();
    bit          full, wAcc, rAcc, hit;
    int          op;
    logic [31:0] hd;
    logic [11:0] eAddr;
    logic [31:0] eWd;
    #4;
    full   = (pq.size() == 4);
    mStall = full && (dmem_wen || dmem_ren);
    wAcc   = dmem_wen && !mStall;
    rAcc   = dmem_ren && !mStall;
    hit    = 0;
    hd     = '0;
    foreach (pq[i]) if (pq[i].a == dmem_raddr) begin
      hit = 1;
      hd  = pq[i].d;
    end
    if (full)               op = 2;
    else if (rAcc && !hit)  op = 1;
    else if (pq.size() > 0) op = 2;
    else                    op = 0;
    eAddr = (op == 1) ? dmem_raddr : (op == 2) ? pq[0].a : 12'h0;
    eWd   = (op == 2) ? pq[0].d : 32'h0;
    chk("m_stall", 32'(dmem_stall), 32'(mStall));
    chk("m_empty", 32'(wb_empty), 32'(pq.size() == 0));
    chk("m_sram_en", 32'(sram_en), 32'(op != 0));
    chk("m_sram_we", 32'(sram_we), 32'(op == 2));
    chk("m_sram_addr", 32'(sram_addr), 32'(eAddr));
    chk("m_sram_wdata", sram_wdata, eWd);
    chk("m_rvalid", 32'(dmem_rvalid), 32'(expRv));
    chk("m_rdata", dmem_rdata, expRd);
    expRv = rAcc;
    expRd = rAcc ? (hit ? hd : memModel[dmem_raddr]) : 32'h0;
    if (op == 2) begin
      memModel[pq[0].a] = pq[0].d;
      void'(pq.pop_front());
    end
    if (wAcc) pq.push_back('{a: dmem_waddr, d: dmem_wdata});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expRv       = 0;
    expRd       = 0;
    mStall      = 0;
    rst_n       = 1'b0;
    setIn(0, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      mem[i]      = $urandom;
      memModel[i] = mem[i];
    end
    mem[12'h010] = 32'h0;        memModel[12'h010] = 32'h0;
    mem[12'h020] = 32'h99;       memModel[12'h020] = 32'h99;
    mem[12'hFFF] = 32'h12345678; memModel[12'hFFF] = 32'h12345678;
    mem[12'h300] = 32'hCAFE0300; memModel[12'h300] = 32'hCAFE0300;

    tbl[0]  = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    tbl[1]  = V(1, 12'h0A5, 32'hDEADBEEF, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    tbl[2]  = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h0A5, 32'hDEADBEEF, 0, 32'h0);
    tbl[3]  = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    tbl[4]  = V(1, 12'h010, 32'h11, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 0, 32'h0);
    tbl[5]  = V(1, 12'h010, 32'h22, 0, 12'h000, 0, 0, 1, 1, 12'h010, 32'h11, 0, 32'h0);
    tbl[6]  = V(0, 12'h000, 32'h0, 1, 12'h010, 0, 0, 1, 1, 12'h010, 32'h22, 0, 32'h0);
    tbl[7]  = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 1, 32'h22);
    tbl[8]  = V(1, 12'h020, 32'h55, 1, 12'h020, 0, 1, 1, 0, 12'h020, 32'h0, 0, 32'h0);
    tbl[9]  = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h020, 32'h55, 1, 32'h99);
    tbl[10] = V(0, 12'h000, 32'h0, 1, 12'h020, 0, 1, 1, 0, 12'h020, 32'h0, 0, 32'h0);
    tbl[11] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 1, 32'h55);
    tbl[12] = V(0, 12'h000, 32'h0, 1, 12'hFFF, 0, 1, 1, 0, 12'hFFF, 32'h0, 0, 32'h0);
    tbl[13] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 1, 32'h12345678);
    tbl[14] = V(1, 12'h100, 32'hA0, 1, 12'h300, 0, 1, 1, 0, 12'h300, 32'h0, 0, 32'h0);
    tbl[15] = V(1, 12'h101, 32'hA1, 1, 12'h300, 0, 0, 1, 0, 12'h300, 32'h0, 1, 32'hCAFE0300);
    tbl[16] = V(1, 12'h102, 32'hA2, 1, 12'h300, 0, 0, 1, 0, 12'h300, 32'h0, 1, 32'hCAFE0300);
    tbl[17] = V(1, 12'h103, 32'hA3, 1, 12'h300, 0, 0, 1, 0, 12'h300, 32'h0, 1, 32'hCAFE0300);
    tbl[18] = V(1, 12'h104, 32'hA4, 1, 12'h300, 1, 0, 1, 1, 12'h100, 32'hA0, 1, 32'hCAFE0300);
    tbl[19] = V(1, 12'h104, 32'hA4, 1, 12'h300, 0, 0, 1, 0, 12'h300, 32'h0, 0, 32'h0);
    tbl[20] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h101, 32'hA1, 1, 32'hCAFE0300);
    tbl[21] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h102, 32'hA2, 0, 32'h0);
    tbl[22] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h103, 32'hA3, 0, 32'h0);
    tbl[23] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 0, 1, 1, 12'h104, 32'hA4, 0, 32'h0);
    tbl[24] = V(0, 12'h000, 32'h0, 0, 12'h000, 0, 1, 0, 0, 12'h000, 32'h0, 0, 32'h0);

    // Reset state, held across edges
    for (int c = 0; c < 2; c++) begin
      #12;
      chk("rst_empty", 32'(wb_empty), 32'h1);
      chk("rst_rvalid", 32'(dmem_rvalid), 32'h0);
      chk("rst_stall", 32'(dmem_stall), 32'h0);
      chk("rst_sram_en", 32'(sram_en), 32'h0);
      chk("rst_rdata", dmem_rdata, 32'h0);
    end
    rst_n = 1'b1;
    nextCycle();

    for (int i = 0; i < 25; i++) begin
      setIn(tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ren, tbl[i].ra);
      modelCheck();
      chk($sformatf("t%0d_stall", i), 32'(dmem_stall), 32'(tbl[i].st));
      chk($sformatf("t%0d_empty", i), 32'(wb_empty), 32'(tbl[i].em));
      chk($sformatf("t%0d_en", i), 32'(sram_en), 32'(tbl[i].en));
      chk($sformatf("t%0d_we", i), 32'(sram_we), 32'(tbl[i].we));
      chk($sformatf("t%0d_addr", i), 32'(sram_addr), 32'(tbl[i].sa));
      chk($sformatf("t%0d_wdata", i), sram_wdata, tbl[i].sw);
      chk($sformatf("t%0d_rvalid", i), 32'(dmem_rvalid), 32'(tbl[i].rv));
      chk($sformatf("t%0d_rdata", i), dmem_rdata, tbl[i].rd);
      nextCycle();
    end

    // Random traffic over a small address pool to force hits
    for (int n = 0; n < 600; n++) begin
      if (!mStall) begin
        setIn($urandom_range(0, 99) < 55,
              12'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 99) < 60,
              12'($urandom_range(0, 9)));
      end
      modelCheck();
      nextCycle();
    end

    setIn(0, 0, 0, 0, 0);
    for (int n = 0; n < 8; n++) begin
      modelCheck();
      nextCycle();
    end

    // Fill three entries behind missing reads, then reset mid-drain
    for (int k = 0; k < 3; k++) begin
      setIn(1, 12'h200 + 12'(k), 32'hB000 + 32'(k), 1, 12'h300);
      modelCheck();
      nextCycle();
    end
    chk("pre_rst_empty", 32'(wb_empty), 32'h0);
    setIn(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_empty", 32'(wb_empty), 32'h1);
    chk("midrst_sram_en", 32'(sram_en), 32'h0);
    chk("midrst_rvalid", 32'(dmem_rvalid), 32'h0);
    pq.delete();
    expRv = 0;
    expRd = 0;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    nextCycle();
    for (int n = 0; n < 4; n++) begin
      modelCheck();
      nextCycle();
    end
    setIn(0, 0, 0, 1, 12'h201);
    modelCheck();
    nextCycle();
    setIn(0, 0, 0, 0, 0);
    modelCheck();
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
